// File: rtl/m_wb_periph_ctrl_if.sv
// rtl/m_wb_periph_ctrl_if.sv - Core-side and slave-side Wishbone signals of the peripheral controller
interface m_wb_periph_ctrl_if #(
  parameter int NSLV = 4
);
  // core side
  logic             CYC_O;
  logic             STB_O;
  logic             WE_O;
  logic [31:0]      ADR_O;
  logic [31:0]      DAT_O;
  logic [3:0]       SEL_O;
  logic             ACK_I;
  logic [31:0]      DAT_I;
  // slave side
  logic [NSLV-1:0]  s_stb;
  logic             s_we;
  logic [31:0]      s_adr;
  logic [31:0]      s_dat;
  logic [3:0]       s_sel;
  logic [NSLV-1:0]  s_ack;
  logic [32*NSLV-1:0] s_rdat;

  // environment view: the core plus the peripheral slaves
  modport master (
    output CYC_O, STB_O, WE_O, ADR_O, DAT_O, SEL_O, s_ack, s_rdat,
    input  ACK_I, DAT_I, s_stb, s_we, s_adr, s_dat, s_sel
  );

  // controller view
  modport slave (
    input  CYC_O, STB_O, WE_O, ADR_O, DAT_O, SEL_O, s_ack, s_rdat,
    output ACK_I, DAT_I, s_stb, s_we, s_adr, s_dat, s_sel
  );
endinterface

// File: rtl/m_wb_periph_ctrl.sv
// rtl/m_wb_periph_ctrl.sv - Wishbone peripheral controller with decode, timeout and optional WBCTRL_BUSERR_EN error capture
module m_wb_periph_ctrl #(
  parameter int NSLV    = 4,
  parameter int ADRLSB  = 28,
  parameter int TOWIDTH = 4,
  parameter int TIMEOUT = 15
) (
  input  logic               CLK_I,
  input  logic               RST_I,
  m_wb_periph_ctrl_if.slave  bus,
  output logic               tmo
`ifdef WBCTRL_BUSERR_EN
  ,
  output logic               berr,
  output logic [31:0]        berr_adr
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state;
  logic [1:0]           sel_q;
  logic [TOWIDTH-1:0]   cnt;

  logic [1:0]           dec_sel;
  logic                 dec_mapped;
  logic                 ack_sel;
  logic [31:0]          rdat_sel;
  logic                 berr_clr;

  // Slaves see the core's address/data/control directly; only the strobe is gated.
  assign bus.s_we  = bus.WE_O;
  assign bus.s_adr = bus.ADR_O;
  assign bus.s_dat = bus.DAT_O;
  assign bus.s_sel = bus.SEL_O;

  assign dec_sel    = bus.ADR_O[ADRLSB+1:ADRLSB];
  assign dec_mapped = (int'(dec_sel) < NSLV);

  // A write of DAT_O[0]=1 to the otherwise unmapped select 3 acknowledges a bus error.
  assign berr_clr = (NSLV < 4) && (dec_sel == 2'd3) && bus.WE_O && bus.DAT_O[0];

  // Pick the latched slave's ack and read data; acks from other slaves never reach the FSM.
  always_comb begin
    ack_sel  = 1'b0;
    rdat_sel = '0;
    for (int k = 0; k < NSLV; k++) begin
      if (sel_q == 2'(k)) begin
        ack_sel  = bus.s_ack[k];
        rdat_sel = bus.s_rdat[32*k +: 32];
      end
    end
  end

  // Access sequencer: decode in IDLE, wait for ack or timeout, one-cycle ACK_I in DONE.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state     <= IDLE;
      sel_q     <= 2'd0;
      cnt       <= '0;
      bus.s_stb <= '0;
      bus.ACK_I <= 1'b0;
      bus.DAT_I <= '0;
      tmo       <= 1'b0;
`ifdef WBCTRL_BUSERR_EN
      berr      <= 1'b0;
      berr_adr  <= '0;
`endif
    end else begin
      bus.ACK_I <= 1'b0;
      tmo       <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.CYC_O && bus.STB_O) begin
            if (dec_mapped) begin
              for (int k = 0; k < NSLV; k++) begin
                bus.s_stb[k] <= (dec_sel == 2'(k));
              end
              sel_q <= dec_sel;
              cnt   <= '0;
              state <= WAIT;
            end else begin
              bus.DAT_I <= '0;
              bus.ACK_I <= 1'b1;
              tmo       <= 1'b1;
              state     <= DONE;
`ifdef WBCTRL_BUSERR_EN
              if (berr_clr) begin
                berr <= 1'b0;
              end else begin
                berr     <= 1'b1;
                berr_adr <= bus.ADR_O;
              end
`endif
            end
          end
        end
        WAIT: begin
          if (!bus.CYC_O) begin
            bus.s_stb <= '0;
            state     <= IDLE;
          end else if (ack_sel) begin
            bus.DAT_I <= rdat_sel;
            bus.ACK_I <= 1'b1;
            bus.s_stb <= '0;
            state     <= DONE;
          end else if (cnt == TOWIDTH'(TIMEOUT)) begin
            bus.DAT_I <= 32'hFFFF_FFFF;
            bus.ACK_I <= 1'b1;
            tmo       <= 1'b1;
            bus.s_stb <= '0;
            state     <= DONE;
`ifdef WBCTRL_BUSERR_EN
            berr      <= 1'b1;
            berr_adr  <= bus.ADR_O;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state     <= IDLE;
          bus.s_stb <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_m_wb_periph_ctrl.sv
// tb/tb_m_wb_periph_ctrl.sv - Scoreboard testbench for m_wb_periph_ctrl
module tb_m_wb_periph_ctrl;

  logic CLK_I;
  logic RST_I;
  logic tmo4, tmo3;
`ifdef WBCTRL_BUSERR_EN
  logic        berr4, berr3;
  logic [31:0] berr_adr4, berr_adr3;
`endif

  m_wb_periph_ctrl_if #(.NSLV(4)) bus4 ();
  m_wb_periph_ctrl_if #(.NSLV(3)) bus3 ();

  m_wb_periph_ctrl #(.NSLV(4), .ADRLSB(28), .TOWIDTH(4), .TIMEOUT(15)) u4 (
    .CLK_I    (CLK_I),
    .RST_I    (RST_I),
    .bus      (bus4.slave),
    .tmo      (tmo4)
`ifdef WBCTRL_BUSERR_EN
    ,
    .berr     (berr4),
    .berr_adr (berr_adr4)
`endif
  );

  m_wb_periph_ctrl #(.NSLV(3), .ADRLSB(28), .TOWIDTH(4), .TIMEOUT(15)) u3 (
    .CLK_I    (CLK_I),
    .RST_I    (RST_I),
    .bus      (bus3.slave),
    .tmo      (tmo3)
`ifdef WBCTRL_BUSERR_EN
    ,
    .berr     (berr3),
    .berr_adr (berr_adr3)
`endif
  );

  initial CLK_I = 1'b0;
  always #5 CLK_I = ~CLK_I;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge CLK_I) cyc <= cyc + 1;

  // slave models for the 4-slave instance: ack after dly[k] strobe cycles, plus forced ack bits
  int         dly[4];
  int         stbcnt[4];
  logic [3:0] stray;
  logic [3:0] ack4;

  always @(posedge CLK_I)
    for (int k = 0; k < 4; k++) stbcnt[k] <= bus4.s_stb[k] ? stbcnt[k] + 1 : 0;

  always_comb begin
    ack4 = '0;
    for (int k = 0; k < 4; k++) ack4[k] = (bus4.s_stb[k] && (stbcnt[k] == dly[k])) || stray[k];
  end

  assign bus4.s_ack  = ack4;
  assign bus4.s_rdat = {32'hCAFE_0003, 32'hCAFE_0002, 32'hCAFE_0001, 32'hCAFE_0000};
  assign bus3.s_ack  = '0;
  assign bus3.s_rdat = {32'hCAFE_0002, 32'hCAFE_0001, 32'hCAFE_0000};

  typedef struct {
    int          cyc;
    logic [31:0] dat;
    logic        tmo;
  } exp_t;

  exp_t q4[$];
  exp_t q3[$];

  logic [3:0]  cur_stb;
  logic        cur_we;
  logic [31:0] cur_adr, cur_dat;
  logic [3:0]  cur_sel;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic [3:0] get_stb(input int d);
    return (d == 0) ? bus4.s_stb : {1'b0, bus3.s_stb};
  endfunction

  function automatic logic get_ack(input int d);
    return (d == 0) ? bus4.ACK_I : bus3.ACK_I;
  endfunction

  task automatic pop_chk(input int d);
    exp_t e;
    if ((d == 0 && q4.size() == 0) || (d == 1 && q3.size() == 0)) begin
      checks++;
      errors++;
      $display("FAIL unexpected_ack: dut %0d got ACK_I=1 expected no response (cycle %0d)", d, cyc);
    end else begin
      if (d == 0) begin
        e = q4.pop_front();
        chk("ack_cycle4", cyc, e.cyc);
        chk("dat_i4", bus4.DAT_I, e.dat);
        chk("tmo4", {31'd0, tmo4}, {31'd0, e.tmo});
        chk("stb_low_ack4", {28'd0, bus4.s_stb}, 32'd0);
      end else begin
        e = q3.pop_front();
        chk("ack_cycle3", cyc, e.cyc);
        chk("dat_i3", bus3.DAT_I, e.dat);
        chk("tmo3", {31'd0, tmo3}, {31'd0, e.tmo});
        chk("stb_low_ack3", {29'd0, bus3.s_stb}, 32'd0);
      end
    end
  endtask

  // monitor: response scoreboard plus slave-side broadcast checks
  always @(negedge CLK_I) begin
    if (!RST_I) begin
      if (bus4.ACK_I) pop_chk(0);
      if (bus3.ACK_I) pop_chk(1);
      if (tmo4 && !bus4.ACK_I) chk("tmo4_without_ack", {31'd0, tmo4}, 32'd0);
      if (tmo3 && !bus3.ACK_I) chk("tmo3_without_ack", {31'd0, tmo3}, 32'd0);
      if (bus4.s_stb != 0) begin
        chk("s_stb_hold", {28'd0, bus4.s_stb}, {28'd0, cur_stb});
        chk("s_we", {31'd0, bus4.s_we}, {31'd0, cur_we});
        chk("s_adr", bus4.s_adr, cur_adr);
        chk("s_dat", bus4.s_dat, cur_dat);
        chk("s_sel", {28'd0, bus4.s_sel}, {28'd0, cur_sel});
      end
      if (bus3.s_stb != 0) chk("s_stb3_unmapped", {29'd0, bus3.s_stb}, 32'd0);
    end
  end

  task automatic drive(input int d, input logic [31:0] adr, input logic we,
                       input logic [31:0] dat, input logic [3:0] sel, input logic [3:0] estb);
    cur_adr = adr; cur_we = we; cur_dat = dat; cur_sel = sel; cur_stb = estb;
    if (d == 0) begin
      bus4.CYC_O = 1'b1; bus4.STB_O = 1'b1; bus4.WE_O = we;
      bus4.ADR_O = adr;  bus4.DAT_O = dat;  bus4.SEL_O = sel;
    end else begin
      bus3.CYC_O = 1'b1; bus3.STB_O = 1'b1; bus3.WE_O = we;
      bus3.ADR_O = adr;  bus3.DAT_O = dat;  bus3.SEL_O = sel;
    end
  endtask

  task automatic release_bus();
    bus4.CYC_O = 1'b0; bus4.STB_O = 1'b0; bus4.WE_O = 1'b0;
    bus3.CYC_O = 1'b0; bus3.STB_O = 1'b0; bus3.WE_O = 1'b0;
  endtask

  // one core access, started just after a rising edge (cycle 0)
  task automatic access(input int d, input logic [31:0] adr, input logic we, input logic [31:0] dat,
                        input logic [3:0] sel, input logic [3:0] estb,
                        input logic [31:0] edat, input logic etmo, input int lat);
    exp_t e;
    logic got;
    e.cyc = cyc + lat; e.dat = edat; e.tmo = etmo;
    if (d == 0) q4.push_back(e); else q3.push_back(e);
    drive(d, adr, we, dat, sel, estb);
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK_I);
      if (i == 1) chk("stb_cycle1", {28'd0, get_stb(d)}, {28'd0, estb});
      if (get_ack(d)) begin
        got = 1'b1;
        break;
      end
      @(posedge CLK_I);
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout: got no ACK_I expected ACK_I within 40 cycles (adr %h)", adr);
    end
    @(posedge CLK_I); #1;
    release_bus();
    @(posedge CLK_I); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    RST_I = 1'b1;
    stray = 4'b0000;
    for (int k = 0; k < 4; k++) dly[k] = -1;
    cur_stb = '0; cur_we = 1'b0; cur_adr = '0; cur_dat = '0; cur_sel = '0;
    release_bus();
    bus4.ADR_O = '0; bus4.DAT_O = '0; bus4.SEL_O = '0;
    bus3.ADR_O = '0; bus3.DAT_O = '0; bus3.SEL_O = '0;
    repeat (2) @(posedge CLK_I);
    #1 RST_I = 1'b0;

    @(negedge CLK_I);
    chk("rst_ack", {31'd0, bus4.ACK_I}, 32'd0);
    chk("rst_dat", bus4.DAT_I, 32'd0);
    chk("rst_stb", {28'd0, bus4.s_stb}, 32'd0);
    chk("rst_tmo", {31'd0, tmo4}, 32'd0);
    @(posedge CLK_I); #1;

    // slave 1 read, ack tied high
    stray = 4'b0010;
    access(0, 32'h1000_0004, 1'b0, 32'h0, 4'hF, 4'b0010, 32'hCAFE_0001, 1'b0, 2);
    stray = 4'b0000;

    // slave 0 write, ack three cycles after strobe
    dly[0] = 3;
    access(0, 32'h0000_0008, 1'b1, 32'h1234_5678, 4'b0011, 4'b0001, 32'hCAFE_0000, 1'b0, 5);
    dly[0] = -1;

    // slave 2 never acks: timeout
    access(0, 32'h2000_0010, 1'b0, 32'h0, 4'hF, 4'b0100, 32'hFFFF_FFFF, 1'b1, 17);
`ifdef WBCTRL_BUSERR_EN
    chk("berr_set", {31'd0, berr4}, 32'd1);
    chk("berr_adr", berr_adr4, 32'h2000_0010);
`endif

    // 3-slave instance, unmapped select 3
    access(1, 32'h3000_0000, 1'b0, 32'h0, 4'hF, 4'b0000, 32'h0, 1'b1, 1);
`ifdef WBCTRL_BUSERR_EN
    chk("berr3_set", {31'd0, berr3}, 32'd1);
    chk("berr3_adr", berr_adr3, 32'h3000_0000);
    access(1, 32'h3000_0000, 1'b1, 32'h1, 4'hF, 4'b0000, 32'h0, 1'b1, 1);
    chk("berr3_clr", {31'd0, berr3}, 32'd0);
`endif

    // abort: CYC_O dropped in cycle 2 of a wait
    drive(0, 32'h2000_0000, 1'b0, 32'h0, 4'hF, 4'b0100);
    repeat (2) begin @(posedge CLK_I); #1; end
    release_bus();
    @(posedge CLK_I);
    @(negedge CLK_I);
    chk("abort_stb", {28'd0, bus4.s_stb}, 32'd0);
    chk("abort_ack", {31'd0, bus4.ACK_I}, 32'd0);
    chk("abort_dat_hold", bus4.DAT_I, 32'hFFFF_FFFF);
    repeat (4) @(posedge CLK_I);
    #1;

    // reset in the middle of a wait
    drive(0, 32'h2000_0000, 1'b0, 32'h0, 4'hF, 4'b0100);
    repeat (3) begin @(posedge CLK_I); #1; end
    RST_I = 1'b1;
    release_bus();
    @(posedge CLK_I); #1;
    RST_I = 1'b0;
    @(negedge CLK_I);
    chk("mid_rst_stb", {28'd0, bus4.s_stb}, 32'd0);
    chk("mid_rst_ack", {31'd0, bus4.ACK_I}, 32'd0);
    chk("mid_rst_dat", bus4.DAT_I, 32'd0);
    chk("mid_rst_tmo", {31'd0, tmo4}, 32'd0);
`ifdef WBCTRL_BUSERR_EN
    chk("mid_rst_berr", {31'd0, berr4}, 32'd0);
`endif
    repeat (3) @(posedge CLK_I);
    #1;

    // normal access after abort/reset
    stray = 4'b0010;
    access(0, 32'h1000_0004, 1'b0, 32'h0, 4'hF, 4'b0010, 32'hCAFE_0001, 1'b0, 2);

    // ack coincides with counter == TIMEOUT, stray ack from slave 0
    stray  = 4'b0001;
    dly[1] = 15;
    access(0, 32'h1000_0000, 1'b0, 32'h0, 4'hF, 4'b0010, 32'hCAFE_0001, 1'b0, 17);
    stray  = 4'b0000;
    dly[1] = -1;

    repeat (5) @(posedge CLK_I);
    #1;
    chk("pending_responses", q4.size() + q3.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/m_wb_periph_ctrl.md
Name: m_wb_periph_ctrl

Overview:
Wishbone peripheral controller between the midgetv core's single-master bus and up to four memory-mapped slaves, for example the LED register, the UART receive sampler and a timer.
- Decodes the core address into one slave select and sequences a single access.
- Routes the selected slave's read data back to the core and returns a registered ACK_I.
- Terminates accesses to unmapped or non-responding slaves with a timeout, so the core can never hang.
- Replaces the ad-hoc "ACK_I <= STB_O" glue in the board top levels.

Parameters:
NSLV, 4, number of slaves (1..4); select values >= NSLV are unmapped.
ADRLSB, 28, LSB of the 2-bit slave-select field, ADR_O[ADRLSB+1:ADRLSB].
TOWIDTH, 4, width of the timeout counter.
TIMEOUT, 15, WAIT cycles without slave ack before forced termination; must be < 2**TOWIDTH.

Ports:
CLK_I  in  1  clock; all logic on the rising edge.
RST_I  in  1  synchronous, active-high reset.
CYC_O  in  1  core cycle.
STB_O  in  1  core strobe.
WE_O  in  1  core write enable.
ADR_O  in  32  core address.
DAT_O  in  32  core write data.
SEL_O  in  4  core byte selects.
ACK_I  out  1  registered acknowledge to the core.
DAT_I  out  32  registered read data to the core.
s_stb  out  NSLV  one-hot slave strobe, registered.
s_we  out  1  WE_O broadcast, combinational.
s_adr  out  32  ADR_O broadcast, combinational.
s_dat  out  32  DAT_O broadcast, combinational.
s_sel  out  4  SEL_O broadcast, combinational.
s_ack  in  NSLV  slave acknowledges.
s_rdat  in  32*NSLV  slave read data; slave k occupies bits [32k+31:32k].
tmo  out  1  one-cycle pulse when an access ends by timeout or unmapped decode.

Behaviour:
- Reset (RST_I=1 at an edge) gives: state IDLE, s_stb=0, ACK_I=0, DAT_I=0, tmo=0, timeout counter=0. Reset wins over every other event, including an access in progress.
- States are IDLE, WAIT and DONE.
- IDLE:
  - On CYC_O & STB_O, decode sel = ADR_O[ADRLSB+1:ADRLSB].
  - If sel < NSLV: set s_stb[sel]=1, latch sel, clear the counter, go to WAIT.
  - Else (unmapped): load DAT_I=0, set tmo=1, go to DONE.
- WAIT:
  - s_stb is held one-hot.
  - If CYC_O=0: abort. Clear s_stb, go to IDLE, no ACK_I.
  - Else if s_ack[sel]=1: load DAT_I = s_rdat slice sel (reads and writes alike), clear s_stb, go to DONE.
  - Else if counter == TIMEOUT: load DAT_I = 32'hFFFF_FFFF, set tmo=1, clear s_stb, go to DONE.
  - Else: increment the counter.
- DONE: ACK_I=1 for exactly this cycle, tmo pulses here when set, then go to IDLE.
- The core drops STB_O in the cycle after it sees ACK_I, so IDLE never restarts the same access. Back-to-back accesses are therefore at least 3 cycles apart.
- Latency:
  - STB_O rises in cycle 0; s_stb is high in cycle 1.
  - A slave acking combinationally in cycle 1 gives ACK_I in cycle 2.
  - Each slave wait state adds one cycle.
  - A timeout gives ACK_I in cycle TIMEOUT+2.
- An s_ack from a non-selected slave is ignored.
- An s_ack arriving in the same cycle the counter hits TIMEOUT counts as a normal ack; ack has priority over timeout.
- DAT_I holds its value outside DONE; it is not cleared.
- The timeout counter never wraps, because it is compared for equality before incrementing.

Optional Feature:
Macro WBCTRL_BUSERR_EN.
- Defined: adds outputs berr (1 bit) and berr_adr (32 bits).
  - On every timeout or unmapped termination, berr is set and berr_adr latches the ADR_O of that access.
  - A later error overwrites berr_adr.
  - berr is sticky; it is cleared only by reset, or by a write to slave select 3 with DAT_O[0]=1 when NSLV<4.
- Undefined: the ports do not exist and there is no extra logic. The tmo pulse remains.

Test Plan:
1. Reset, then read slave 1 (ADR_O=32'h1000_0004) with s_ack[1] tied high and s_rdat slice 1 = 32'hCAFE_0001 -> s_stb=4'b0010 in cycle 1; ACK_I=1 and DAT_I=32'hCAFE_0001 in cycle 2; tmo=0.
2. Write to slave 0 whose ack comes 3 cycles after s_stb rises -> s_we=1, s_dat=DAT_O throughout; ACK_I exactly one cycle after s_ack; s_stb low in the ACK_I cycle.
3. Access slave 2 with s_ack never asserted, TIMEOUT=15 -> ACK_I in cycle 17 with DAT_I=32'hFFFF_FFFF and tmo=1; with WBCTRL_BUSERR_EN, berr=1 and berr_adr=ADR_O.
4. NSLV=3, access ADR_O=32'h3000_0000 -> no s_stb bit ever set; ACK_I in cycle 1, DAT_I=0, tmo=1.
5. Drop CYC_O in cycle 2 of a WAIT, and separately assert RST_I mid-WAIT -> s_stb=0 and state IDLE next cycle, no ACK_I; the following normal access completes correctly.
6. s_ack[sel] rises in the same cycle the counter reaches TIMEOUT, with a stray s_ack[0] during a slave-1 access -> the access completes with slave data, tmo=0, and the stray ack has no effect.
